// File: rtl/usb_data_packet_rx_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_data_packet_rx_filter_if
// Description : Bundles the decoded receive byte stream, the buffer-full flag
//               and the endpoint fill outputs of usb_data_packet_rx_filter.
//               slave  = filter side, master = PHY/endpoint side.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_data_packet_rx_filter_if;
    logic       rxValid_i;
    logic [7:0] rxData_i;
    logic       rxEop_i;
    logic       rxError_i;
    logic       full_i;
    logic       byteIsData_o;
    logic       dataValid_o;
    logic [7:0] data_o;
    logic       fillTransDone_o;
    logic       fillTransSuccess_o;

    modport slave (
        input  rxValid_i, rxData_i, rxEop_i, rxError_i, full_i,
        output byteIsData_o, dataValid_o, data_o, fillTransDone_o, fillTransSuccess_o
    );

    modport master (
        output rxValid_i, rxData_i, rxEop_i, rxError_i, full_i,
        input  byteIsData_o, dataValid_o, data_o, fillTransDone_o, fillTransSuccess_o
    );
endinterface
`default_nettype wire

// File: rtl/usb_data_packet_rx_filter.sv
`default_nettype none
// ============================================================================
// Module      : usb_data_packet_rx_filter
// Description : Forwards PID and payload of a received USB DATA packet to the
//               OUT endpoint fill interface, strips the trailing CRC16 and
//               ends every packet with one commit/rollback strobe.
//               Optional payload length check: define USB_RX_LEN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_data_packet_rx_filter #(
    parameter int MAX_PACKET_SIZE = 64
) (
    input  wire                          clk12_i,
    input  wire                          rst_i,
    usb_data_packet_rx_filter_if.slave   rx_if
);

    localparam logic [15:0] C_CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] C_CRC_RESIDUAL = 16'hB001;
    localparam logic [15:0] C_CRC_POLY     = 16'hA001;

    // The saturating 11-bit counter must be able to reach MAX_PACKET_SIZE + 1.
    if (MAX_PACKET_SIZE < 1 || MAX_PACKET_SIZE > 2046) begin : g_bad_max_packet_size
        $error("MAX_PACKET_SIZE must lie in 1..2046");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold0_q, hold0_d;      // oldest held byte
    logic [7:0]  hold1_q, hold1_d;      // newest held byte
    logic [1:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic        fail_q, fail_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        byte_is_data_q, byte_is_data_d;
    logic        done_q, done_d;
    logic        success_q, success_d;
    logic        w_end_pkt;
    logic        w_pid_ok;
    logic        w_len_over;

`ifdef USB_RX_LEN_CHECK_EN
    localparam logic [10:0] C_MAX_LEN = 11'(MAX_PACKET_SIZE);
    logic [10:0] len_cnt_q, len_cnt_d;
    assign w_len_over = (len_cnt_q == C_MAX_LEN);
`else
    assign w_len_over = 1'b0;
`endif

    // Reflected CRC16, one whole byte per call, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Data PIDs have a valid check nibble and end in 2'b11.
    assign w_pid_ok = (rxData_i_chk(rx_if.rxData_i));

    function automatic logic rxData_i_chk(input logic [7:0] pid);
        return (pid[3:0] == ~pid[7:4]) && (pid[1:0] == 2'b11);
    endfunction

    // Next-state logic: packet sequencing, holding pipeline, CRC and strobes.
    always_comb begin
        state_d        = state_q;
        hold0_d        = hold0_q;
        hold1_d        = hold1_q;
        hold_cnt_d     = hold_cnt_q;
        crc_d          = crc_q;
        fail_d         = fail_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        byte_is_data_d = byte_is_data_q;
        done_d         = 1'b0;
        success_d      = 1'b0;
        w_end_pkt      = 1'b0;
`ifdef USB_RX_LEN_CHECK_EN
        len_cnt_d      = len_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A stray EOP with no packet in flight is ignored entirely.
                if (rx_if.rxValid_i && !rx_if.rxEop_i) begin
                    data_d         = rx_if.rxData_i;
                    byte_is_data_d = 1'b0;
                    if (w_pid_ok) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_PAYLOAD: begin
                byte_is_data_d = 1'b1;
                if (rx_if.rxEop_i) begin
                    // A byte arriving with EOP is discarded and fails the packet.
                    done_d    = 1'b1;
                    success_d = (hold_cnt_q == 2'd2) && (crc_q == C_CRC_RESIDUAL) &&
                                !fail_q && !rx_if.rxValid_i && !rx_if.rxError_i;
                    w_end_pkt = 1'b1;
                end else if (rx_if.rxError_i) begin
                    fail_d  = 1'b1;
                    state_d = S_DRAIN;
                end else if (rx_if.rxValid_i) begin
                    crc_d = crc16_byte(crc_q, rx_if.rxData_i);
                    if (hold_cnt_q == 2'd2) begin
                        // The oldest held byte is now known not to be CRC.
                        if (rx_if.full_i || w_len_over) begin
                            fail_d  = 1'b1;
                            state_d = S_DRAIN;
                        end else begin
                            data_d       = hold0_q;
                            data_valid_d = 1'b1;
                            hold0_d      = hold1_q;
                            hold1_d      = rx_if.rxData_i;
`ifdef USB_RX_LEN_CHECK_EN
                            if (len_cnt_q != 11'h7FF) begin
                                len_cnt_d = len_cnt_q + 11'd1;
                            end
`endif
                        end
                    end else if (hold_cnt_q == 2'd1) begin
                        hold1_d    = rx_if.rxData_i;
                        hold_cnt_d = 2'd2;
                    end else begin
                        hold0_d    = rx_if.rxData_i;
                        hold_cnt_d = 2'd1;
                    end
                end
            end

            S_DRAIN: begin
                if (rx_if.rxEop_i) begin
                    done_d    = 1'b1;
                    success_d = 1'b0;
                    w_end_pkt = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every packet end rearms the filter for the next PID.
        if (w_end_pkt) begin
            state_d        = S_IDLE;
            crc_d          = C_CRC_INIT;
            hold_cnt_d     = 2'd0;
            fail_d         = 1'b0;
            byte_is_data_d = 1'b0;
`ifdef USB_RX_LEN_CHECK_EN
            len_cnt_d      = 11'd0;
`endif
        end
    end

    // State and registered outputs; reset aborts any packet without a strobe.
    always_ff @(posedge clk12_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            hold0_q        <= 8'h00;
            hold1_q        <= 8'h00;
            hold_cnt_q     <= 2'd0;
            crc_q          <= C_CRC_INIT;
            fail_q         <= 1'b0;
            data_q         <= 8'h00;
            data_valid_q   <= 1'b0;
            byte_is_data_q <= 1'b0;
            done_q         <= 1'b0;
            success_q      <= 1'b0;
`ifdef USB_RX_LEN_CHECK_EN
            len_cnt_q      <= 11'd0;
`endif
        end else begin
            state_q        <= state_d;
            hold0_q        <= hold0_d;
            hold1_q        <= hold1_d;
            hold_cnt_q     <= hold_cnt_d;
            crc_q          <= crc_d;
            fail_q         <= fail_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            byte_is_data_q <= byte_is_data_d;
            done_q         <= done_d;
            success_q      <= success_d;
`ifdef USB_RX_LEN_CHECK_EN
            len_cnt_q      <= len_cnt_d;
`endif
        end
    end

    assign rx_if.data_o             = data_q;
    assign rx_if.dataValid_o        = data_valid_q;
    assign rx_if.byteIsData_o       = byte_is_data_q;
    assign rx_if.fillTransDone_o    = done_q;
    assign rx_if.fillTransSuccess_o = success_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_data_packet_rx_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_data_packet_rx_filter
// Description : Self-checking bench for usb_data_packet_rx_filter: directed
//               packets followed by randomized packets, each compared with a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_data_packet_rx_filter;

`ifdef USB_RX_LEN_CHECK_EN
    localparam int MAXP    = 8;
    localparam int RND_MAX = 12;
`else
    localparam int MAXP    = 64;
    localparam int RND_MAX = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_data_packet_rx_filter_if bus ();

    usb_data_packet_rx_filter #(.MAX_PACKET_SIZE(MAXP)) dut (
        .clk12_i (clk),
        .rst_i   (rst),
        .rx_if   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] pkt [0:79];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         done_cnt;
    int         stray_succ;
    logic       last_succ;
    logic       bid_seen;
    logic       exp_succ;
    logic       exp_bid;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.dataValid_o) got_q.push_back(bus.data_o);
        if (bus.fillTransDone_o) begin
            done_cnt++;
            last_succ = bus.fillTransSuccess_o;
        end else if (bus.fillTransSuccess_o) begin
            stray_succ++;
        end
        if (bus.byteIsData_o) bid_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc16(input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {8'h00, pkt[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Appends the transmitted CRC (complemented, low byte first).
    task automatic add_crc(input int p, input bit corrupt);
        logic [15:0] c;
        c = crc16(p);
        pkt[p]   = ~c[7:0];
        pkt[p+1] = ~c[15:8] ^ (corrupt ? 8'h01 : 8'h00);
    endtask

    function automatic logic crc_ok(input int n);
        logic [15:0] c;
        if (n < 2) return 1'b0;
        c = crc16(n - 2);
        return (pkt[n-2] == ~c[7:0]) && (pkt[n-1] == ~c[15:8]);
    endfunction

    // Packet-level model: the last two bytes before EOP are the CRC, every
    // earlier byte is payload, written out once two later bytes have arrived.
    task automatic model(input logic [7:0] pid, input int n, input int full_at,
                         input int err_at, input bit eop_last);
        int m;
        bit fail;
        bit pid_ok;
        exp_q.delete();
        fail   = 0;
        pid_ok = (pid[3:0] == ~pid[7:4]) && (pid[1:0] == 2'b11);
        m      = eop_last ? n - 1 : n;
        if (!pid_ok) begin
            fail = 1;
        end else begin
            for (int k = 0; k < m; k++) begin
                if (k == err_at) break;
                if (k >= 2) begin
                    if (full_at >= 0 && k >= full_at) begin fail = 1; break; end
`ifdef USB_RX_LEN_CHECK_EN
                    if (exp_q.size() == MAXP) begin fail = 1; break; end
`endif
                    exp_q.push_back(pkt[k-2]);
                end
            end
        end
        if (err_at >= 0 || eop_last || n < 2) fail = 1;
        exp_succ = !fail && crc_ok(n);
        exp_bid  = pid_ok && (m > 0 || err_at >= 0);
    endtask

    task automatic send_pkt(input logic [7:0] pid, input int n, input int full_at,
                            input int err_at, input bit eop_last, input bit gaps);
        got_q.delete();
        done_cnt   = 0;
        stray_succ = 0;
        bid_seen   = 1'b0;
        last_succ  = 1'b0;
        bus.rxValid_i = 1'b1;
        bus.rxData_i  = pid;
        tick();
        bus.rxValid_i = 1'b0;
        check("pid_on_data", 32'(bus.data_o), 32'(pid));
        check("pid_dv_low", 32'(bus.dataValid_o), 32'd0);
        check("pid_bid_low", 32'(bus.byteIsData_o), 32'd0);
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (k == err_at) begin
                bus.rxError_i = 1'b1;
                tick();
                bus.rxError_i = 1'b0;
            end
            if (full_at >= 0 && k >= full_at) bus.full_i = 1'b1;
            bus.rxValid_i = 1'b1;
            bus.rxData_i  = pkt[k];
            if (eop_last && k == n - 1) bus.rxEop_i = 1'b1;
            tick();
            bus.rxValid_i = 1'b0;
            bus.rxEop_i   = 1'b0;
        end
        if (!(eop_last && n > 0)) begin
            bus.rxEop_i = 1'b1;
            tick();
            bus.rxEop_i = 1'b0;
        end
        repeat (3) tick();
        bus.full_i = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, ":count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ":byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, ":done"}, 32'(done_cnt), 32'd1);
        check({tag, ":success"}, 32'(last_succ), 32'(exp_succ));
        check({tag, ":bid_seen"}, 32'(bid_seen), 32'(exp_bid));
        check({tag, ":stray_success"}, 32'(stray_succ), 32'd0);
        check({tag, ":bid_after"}, 32'(bus.byteIsData_o), 32'd0);
    endtask

    task automatic run(input string tag, input logic [7:0] pid, input int n, input int full_at,
                       input int err_at, input bit eop_last, input bit gaps);
        model(pid, n, full_at, err_at, eop_last);
        send_pkt(pid, n, full_at, err_at, eop_last, gaps);
        compare(tag);
    endtask

    initial begin
        logic [7:0] lit [3];
        logic [7:0] pids [4];
        lit  = '{8'h11, 8'h22, 8'h33};
        pids = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
        bus.rxValid_i = 1'b0;
        bus.rxData_i  = 8'h00;
        bus.rxEop_i   = 1'b0;
        bus.rxError_i = 1'b0;
        bus.full_i    = 1'b0;
        done_cnt      = 0;
        stray_succ    = 0;
        bid_seen      = 1'b0;
        last_succ     = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        check("rst:data", 32'(bus.data_o), 32'd0);
        check("rst:dv", 32'(bus.dataValid_o), 32'd0);
        check("rst:bid", 32'(bus.byteIsData_o), 32'd0);
        check("rst:done", 32'(bus.fillTransDone_o), 32'd0);
        check("rst:succ", 32'(bus.fillTransSuccess_o), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // DATA0 with three payload bytes.
        for (int i = 0; i < 3; i++) pkt[i] = lit[i];
        add_crc(3, 1'b0);
        run("data0", 8'hC3, 5, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            check("data0:literal", 32'(got_q.size() > i ? got_q[i] : 8'hxx), 32'(lit[i]));

        // Zero-length DATA1.
        add_crc(0, 1'b0);
        check("zlp:crc_lo", 32'(pkt[0]), 32'h00);
        run("zlp", 8'h4B, 2, -1, -1, 1'b0, 1'b0);

        // Corrupted CRC.
        for (int i = 0; i < 3; i++) pkt[i] = lit[i];
        add_crc(3, 1'b1);
        run("bad_crc", 8'hC3, 5, -1, -1, 1'b0, 1'b0);

        // Invalid PID.
        for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
        run("bad_pid", 8'hC2, 4, -1, -1, 1'b0, 1'b0);

        // Buffer full while payload byte 2 would be written.
        for (int i = 0; i < 5; i++) pkt[i] = 8'($urandom);
        add_crc(5, 1'b0);
        run("overflow", 8'h87, 7, 4, -1, 1'b0, 1'b0);

`ifdef USB_RX_LEN_CHECK_EN
        // One payload byte beyond the limit.
        for (int i = 0; i < 9; i++) pkt[i] = 8'($urandom);
        add_crc(9, 1'b0);
        run("too_long", 8'hC3, 11, -1, -1, 1'b0, 1'b0);
`endif

        // EOP arriving together with the last CRC byte.
        for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
        add_crc(4, 1'b0);
        run("eop_with_byte", 8'h4B, 6, -1, -1, 1'b1, 1'b0);

        // Receive error in the middle of the payload.
        run("rx_error", 8'h4B, 6, -1, 3, 1'b0, 1'b0);

        // Reset mid-packet, then a fresh good packet.
        got_q.delete();
        done_cnt   = 0;
        stray_succ = 0;
        bus.rxValid_i = 1'b1;
        bus.rxData_i  = 8'hC3;
        tick();
        bus.rxData_i  = 8'h5A;
        tick();
        bus.rxData_i  = 8'hA5;
        tick();
        bus.rxValid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_mid:done", 32'(done_cnt), 32'd0);
        check("rst_mid:bid", 32'(bus.byteIsData_o), 32'd0);
        check("rst_mid:data", 32'(bus.data_o), 32'd0);
        for (int i = 0; i < 3; i++) pkt[i] = lit[i];
        add_crc(3, 1'b0);
        run("after_rst", 8'hC3, 5, -1, -1, 1'b0, 1'b0);

        // Randomized packets.
        for (int t = 0; t < 40; t++) begin
            int         p, n, full_at, err_at;
            bit         eop_last, gaps;
            logic [7:0] pid;
            p = $urandom_range(0, RND_MAX);
            for (int i = 0; i < p; i++) pkt[i] = 8'($urandom);
            add_crc(p, $urandom_range(0, 4) == 0);
            n = p + 2;
            if ($urandom_range(0, 7) == 0) n = $urandom_range(0, n);
            pid      = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pids[$urandom_range(0, 3)];
            full_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : -1;
            err_at   = ($urandom_range(0, 7) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            eop_last = ($urandom_range(0, 7) == 0) && (n >= 2);
            gaps     = 1'($urandom_range(0, 1));
            run("random", pid, n, full_at, err_at, eop_last, gaps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
